// File: rtl/jtag_pkg.sv
// jtag_pkg: op/state types and TAP walk constants shared by the scan sequencer
package jtag_pkg;
  typedef enum logic [1:0] {OP_RESET, OP_IR_SCAN, OP_DR_SCAN, OP_RUN_IDLE} jtag_op_t;
  typedef enum logic [2:0] {S_WAIT, S_RST_WALK, S_PRE, S_SHIFT, S_POST, S_RTI, S_DONE} seq_state_t;
  localparam int WALK_TICKS = 6;
  localparam int IR_PRE_TICKS = 4;
  localparam int DR_PRE_TICKS = 3;
  localparam int POST_TICKS = 2;
  // bit i is the TMS value on tick i of the phase
  localparam logic [5:0] WALK_TMS = 6'b011111;
  localparam logic [3:0] IR_PRE_TMS = 4'b0011;
  localparam logic [3:0] DR_PRE_TMS = 4'b0001;
  localparam logic [1:0] POST_TMS = 2'b01;
  function automatic logic is_scan(jtag_op_t op);
    return op == OP_IR_SCAN || op == OP_DR_SCAN;
  endfunction
endpackage

// File: rtl/jtag_tick_gen.sv
// jtag_tick_gen: divides internal_clk down to a one-cycle TAP advance tick
module jtag_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic internal_clk,
  input  logic tap_rst,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == CW'(CLK_DIV - 1);
  assign tick = run && !tap_rst && wrap;
  always_ff @(posedge internal_clk) begin
    if (tap_rst || clear) cnt <= '0;
    else if (run) cnt <= wrap ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: turns scan commands into TMS/TDI tick streams and gathers TDO
module jtag_scan_sequencer
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 4,
  localparam int LENW = $clog2(MAX_LEN + 1)
) (
  input  logic               internal_clk,
  input  logic               tap_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LENW-1:0]    cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tap_clk_enable,
  output logic               tap_mode,
  output logic               tdi,
  input  logic               tdo
);
  localparam int IW = $clog2(MAX_LEN);
  seq_state_t state, nstate;
  jtag_op_t op_q, sel_op;
  logic [LENW-1:0] len_q, elen, sel_len, idx, nidx;
  logic [MAX_LEN-1:0] data_q, sel_data, cap;
  logic at_idle, accept, run, tick, last, tms_n, tdi_n;

  function automatic seq_state_t after(seq_state_t s, jtag_op_t op, logic [LENW-1:0] len);
    return s == S_RST_WALK ? (op == OP_RESET ? S_DONE :
                              op == OP_RUN_IDLE ? (len != '0 ? S_RTI : S_DONE) : S_PRE) :
           s == S_PRE ? S_SHIFT : s == S_SHIFT ? S_POST : S_DONE;
  endfunction

  function automatic logic [LENW-1:0] plen(seq_state_t s, jtag_op_t op, logic [LENW-1:0] len);
    return s == S_RST_WALK ? LENW'(WALK_TICKS) :
           s == S_PRE ? (op == OP_IR_SCAN ? LENW'(IR_PRE_TICKS) : LENW'(DR_PRE_TICKS)) :
           (s == S_SHIFT || s == S_RTI) ? len : LENW'(POST_TICKS);
  endfunction

  function automatic logic tms_of(seq_state_t s, logic [LENW-1:0] i, jtag_op_t op, logic [LENW-1:0] len);
    return s == S_RST_WALK ? WALK_TMS[i[2:0]] :
           s == S_PRE ? (op == OP_IR_SCAN ? IR_PRE_TMS[i[1:0]] : DR_PRE_TMS[i[1:0]]) :
           s == S_SHIFT ? i == len - 1'b1 :
           s == S_POST ? POST_TMS[i[0]] : 1'b0;
  endfunction

  assign accept = cmd_valid && cmd_ready;
  assign run = state != S_WAIT && state != S_DONE;
  assign tap_clk_enable = tick;
  assign elen = !is_scan(jtag_op_t'(cmd_op)) ? cmd_len :
                cmd_len == '0 ? LENW'(1) : cmd_len > LENW'(MAX_LEN) ? LENW'(MAX_LEN) : cmd_len;
  assign sel_op = accept ? jtag_op_t'(cmd_op) : op_q;
  assign sel_len = accept ? elen : len_q;
  assign sel_data = accept ? cmd_data : data_q;
  assign last = idx == plen(state, op_q, len_q) - 1'b1;
  // an unknown TAP position or an explicit RESET forces the walk first
  assign nstate = accept ? (!at_idle || sel_op == OP_RESET ? S_RST_WALK : after(S_RST_WALK, sel_op, sel_len)) :
                  last ? after(state, op_q, len_q) : state;
  assign nidx = accept || last ? '0 : idx + 1'b1;
  assign tms_n = tms_of(nstate, nidx, sel_op, sel_len);
  assign tdi_n = nstate == S_SHIFT && sel_data[nidx[IW-1:0]];

  jtag_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .internal_clk(internal_clk),
    .tap_rst(tap_rst),
    .clear(accept),
    .run(run),
    .tick(tick)
  );

  always_ff @(posedge internal_clk) begin
    if (tap_rst) begin
      state <= S_WAIT;
      idx <= '0;
      at_idle <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      tap_mode <= 1'b1;
      tdi <= 1'b0;
      cap <= '0;
      op_q <= OP_RESET;
      len_q <= '0;
      data_q <= '0;
    end else begin
      rsp_valid <= 1'b0;
      cmd_ready <= !accept && (state == S_WAIT || state == S_DONE);
      if (accept) begin
        op_q <= sel_op;
        len_q <= elen;
        data_q <= cmd_data;
        cap <= '0;
      end
      if (tick && state == S_SHIFT) cap[idx[IW-1:0]] <= tdo;
      if (accept || tick) begin
        state <= nstate;
        idx <= nidx;
        tap_mode <= tms_n;
        tdi <= tdi_n;
        if (nstate == S_DONE) begin
          rsp_valid <= 1'b1;
          rsp_data <= accept ? '0 : cap;
          at_idle <= 1'b1;
        end
      end else if (state == S_DONE) state <= S_WAIT;
    end
  end
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// tb_jtag_scan_sequencer: tick-stream model checks for CLK_DIV=4 and back-to-back CLK_DIV=1
module tb_jtag_scan_sequencer;
  localparam int MAX_LEN = 32;
  localparam int D = 4;
  localparam int LENW = 6;
  logic internal_clk = 1'b0;
  logic tap_rst = 1'b1;
  always #5 internal_clk = ~internal_clk;

  logic cmd_valid = 1'b0, cmd_ready, rsp_valid, tap_clk_enable, tap_mode, tdi, tdo;
  logic [1:0] cmd_op = '0;
  logic [LENW-1:0] cmd_len = '0;
  logic [31:0] cmd_data = '0, rsp_data;
  int tdo_mode = 0;
  assign tdo = tdo_mode == 1 ? tdi : tdo_mode == 2;

  logic cmd_valid_b = 1'b0, cmd_ready_b, rsp_valid_b, tck_b, tms_b, tdi_b;
  logic [1:0] cmd_op_b = '0;
  logic [LENW-1:0] cmd_len_b = '0;
  logic [31:0] cmd_data_b = '0, rsp_data_b;

  jtag_scan_sequencer #(.MAX_LEN(MAX_LEN), .CLK_DIV(D)) dut (
    .internal_clk(internal_clk), .tap_rst(tap_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tap_clk_enable(tap_clk_enable), .tap_mode(tap_mode), .tdi(tdi), .tdo(tdo));

  jtag_scan_sequencer #(.MAX_LEN(MAX_LEN), .CLK_DIV(1)) dut_b (
    .internal_clk(internal_clk), .tap_rst(tap_rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op_b), .cmd_len(cmd_len_b), .cmd_data(cmd_data_b), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .tap_clk_enable(tck_b), .tap_mode(tms_b), .tdi(tdi_b), .tdo(tdi_b));

  int total = 0, bad = 0;
  int exp_tms[$], exp_tdi[$];
  logic [31:0] exp_rsp, last_rsp;
  int last_ticks;
  bit model_idle = 0, idle_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // expected per-tick TMS/TDI streams straight from the command rules; tdi -1 = not a shift tick
  function automatic void build(input int op, input int len, input logic [31:0] data, input bit idle, input int mode);
    int l;
    logic [31:0] mask;
    exp_tms = {};
    exp_tdi = {};
    exp_rsp = '0;
    if (!idle || op == 0) begin
      exp_tms = {1, 1, 1, 1, 1, 0};
      exp_tdi = {-1, -1, -1, -1, -1, -1};
    end
    if (op == 1 || op == 2) begin
      l = len == 0 ? 1 : len > MAX_LEN ? MAX_LEN : len;
      if (op == 1) begin exp_tms.push_back(1); exp_tdi.push_back(-1); end
      exp_tms.push_back(1); exp_tms.push_back(0); exp_tms.push_back(0);
      repeat (3) exp_tdi.push_back(-1);
      for (int i = 0; i < l; i++) begin
        exp_tms.push_back(int'(i == l - 1));
        exp_tdi.push_back(int'(data[i]));
      end
      exp_tms.push_back(1); exp_tms.push_back(0);
      repeat (2) exp_tdi.push_back(-1);
      mask = l == 32 ? 32'hFFFF_FFFF : (32'd1 << l) - 32'd1;
      exp_rsp = mode == 1 ? data & mask : mode == 2 ? mask : 32'd0;
    end else if (op == 3) begin
      for (int i = 0; i < len; i++) begin exp_tms.push_back(0); exp_tdi.push_back(-1); end
    end
  endfunction

  task automatic run_cmd(input int op, input int len, input logic [31:0] data, input int abort_tick);
    int t, w;
    build(op, len, data, model_idle, tdo_mode);
    t = exp_tms.size();
    last_ticks = 0;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 200) begin @(negedge internal_clk); w++; end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_len = LENW'(len); cmd_data = data;
    for (int j = 1; j <= t * D + 2; j++) begin
      @(negedge internal_clk);
      cmd_valid = 1'b0;
      if (tap_clk_enable === 1'b1) last_ticks++;
      if (j <= t * D) begin
        chk("tick", tap_clk_enable, j % D == 0);
        chk("tms", tap_mode, exp_tms[(j - 1) / D]);
        if (exp_tdi[(j - 1) / D] >= 0) chk("tdi", tdi, exp_tdi[(j - 1) / D]);
        chk("rsp_early", rsp_valid, 0);
        chk("ready_busy", cmd_ready, 0);
        if (abort_tick != 0 && j == abort_tick * D) begin
          tap_rst = 1'b1;
          @(negedge internal_clk);
          chk("abort_rsp", rsp_valid, 0);
          chk("abort_tms", tap_mode, 1);
          chk("abort_tck", tap_clk_enable, 0);
          chk("abort_ready", cmd_ready, 0);
          chk("abort_data", rsp_data, 0);
          @(negedge internal_clk);
          tap_rst = 1'b0;
          @(negedge internal_clk);
          chk("abort_rsp2", rsp_valid, 0);
          chk("abort_ready_after", cmd_ready, 1);
          model_idle = 0;
          return;
        end
      end else if (j == t * D + 1) begin
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp_rsp);
        chk("tick_done", tap_clk_enable, 0);
        chk("ready_done", cmd_ready, 0);
        last_rsp = rsp_data;
      end else begin
        chk("rsp_pulse", rsp_valid, 0);
        chk("rsp_hold", rsp_data, exp_rsp);
        chk("ready_back", cmd_ready, 1);
      end
    end
    model_idle = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ops[4] = '{2, 3, 1, 3};
    int lens[4] = '{4, 0, 3, 2};
    logic [31:0] datas[4] = '{32'h9, 32'h0, 32'h5, 32'h0};
    int t;
    @(negedge internal_clk);
    @(negedge internal_clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_tck", tap_clk_enable, 0);
    chk("rst_tms", tap_mode, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_tms_b", tms_b, 1);
    tap_rst = 1'b0;
    @(negedge internal_clk);
    chk("ready_after_rst", cmd_ready, 1);

    tdo_mode = 1;
    run_cmd(2, 8, 32'hA5, 0);
    chk("cold_ticks", last_ticks, 19);
    chk("cold_rsp", last_rsp, 32'hA5);
    tdo_mode = 0;
    run_cmd(1, 5, 32'h1F, 0);
    chk("ir_ticks", last_ticks, 11);
    chk("ir_rsp", last_rsp, 0);
    tdo_mode = 1;
    run_cmd(2, 0, 32'h3, 0);
    chk("len0_ticks", last_ticks, 6);
    chk("len0_rsp", last_rsp, 32'h1);
    run_cmd(2, 40, 32'h8000_0001, 0);
    chk("len40_ticks", last_ticks, 37);
    chk("len40_rsp", last_rsp, 32'h8000_0001);
    tdo_mode = 2;
    run_cmd(2, 12, 32'h0, 0);
    chk("ones_rsp", last_rsp, 32'hFFF);
    tdo_mode = 1;
    run_cmd(3, 0, 32'h0, 0);
    chk("idle0_ticks", last_ticks, 0);
    run_cmd(3, 3, 32'h0, 0);
    chk("idle3_ticks", last_ticks, 3);
    run_cmd(0, 0, 32'h0, 0);
    chk("reset_ticks", last_ticks, 6);
    run_cmd(2, 16, 32'h1234, 7);
    run_cmd(1, 5, 32'h0A, 0);
    chk("post_abort_ticks", last_ticks, 17);
    chk("post_abort_rsp", last_rsp, 32'h0A);

    // CLK_DIV=1 with cmd_valid held high: tick every cycle, accepts exactly T+2 apart
    idle_b = 0;
    cmd_valid_b = 1'b1; cmd_op_b = 2'(ops[0]); cmd_len_b = LENW'(lens[0]); cmd_data_b = datas[0];
    chk("b2b_ready0", cmd_ready_b, 1);
    for (int c = 0; c < 4; c++) begin
      build(ops[c], lens[c], datas[c], idle_b, 1);
      t = exp_tms.size();
      for (int j = 1; j <= t + 2; j++) begin
        @(negedge internal_clk);
        if (j == 1) begin
          if (c < 3) begin
            cmd_op_b = 2'(ops[c + 1]); cmd_len_b = LENW'(lens[c + 1]); cmd_data_b = datas[c + 1];
          end else cmd_valid_b = 1'b0;
        end
        if (j <= t) begin
          chk("b2b_tick", tck_b, 1);
          chk("b2b_tms", tms_b, exp_tms[j - 1]);
          if (exp_tdi[j - 1] >= 0) chk("b2b_tdi", tdi_b, exp_tdi[j - 1]);
          chk("b2b_ready_busy", cmd_ready_b, 0);
        end else if (j == t + 1) begin
          chk("b2b_tick_done", tck_b, 0);
          chk("b2b_rsp", rsp_valid_b, 1);
          chk("b2b_rsp_data", rsp_data_b, exp_rsp);
          chk("b2b_ready_done", cmd_ready_b, 0);
        end else begin
          chk("b2b_ready", cmd_ready_b, 1);
          chk("b2b_rsp_pulse", rsp_valid_b, 0);
        end
      end
      idle_b = 1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
